bp_gshare_ras: RTL
==================

Name: bp_gshare_ras

Overview:
- Parametrised next-generation fetch-stage direction predictor and return-address stack.
- Pattern history table (PHT) of saturating counters, selectable bimodal or gshare indexing.
- Speculative global history; circular RAS with overwrite-on-overflow; single-cycle checkpoint restore on mispredict.
- Sits beside the fetch PC logic: fetch issues lookups, backend returns resolved-branch updates and recovery checkpoints.

Parameters:
- IDX_W, 9, PHT index width; PHT holds 2**IDX_W entries.
- CTR_W, 2, saturating counter width (>=1).
- HIST_W, 6, global history length; legal range 0..IDX_W.
- MODE, 1, 0 = bimodal (history ignored), 1 = gshare.
- RAS_DEPTH, 4, RAS entries, power of two, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lk_valid  in  1  lookup request this cycle
- lk_pc  in  32  PC of the fetched instruction
- lk_is_br  in  1  instruction is a conditional branch
- lk_push  in  1  call: push lk_pc+4
- lk_pop  in  1  return: pop top of stack
- pred_valid  out  1  prediction valid (one cycle after lk_valid)
- pred_taken  out  1  predicted direction (0 if not a branch)
- ras_valid  out  1  ras_target is usable (RAS was non-empty at pop)
- ras_target  out  32  popped return address
- ckpt_hist  out  HIST_W  history used for this prediction (carried down the pipe)
- ckpt_ras_ptr  out  $clog2(RAS_DEPTH)  RAS top pointer before this lookup
- ckpt_ras_cnt  out  $clog2(RAS_DEPTH)+1  RAS occupancy before this lookup
- upd_valid  in  1  resolved conditional branch
- upd_pc  in  32  PC of the resolved branch
- upd_hist  in  HIST_W  checkpointed history of the resolved branch
- upd_taken  in  1  actual direction
- rec_valid  in  1  mispredict recovery
- rec_hist  in  HIST_W  history to restore, with the correct outcome already appended
- rec_ras_ptr  in  $clog2(RAS_DEPTH)  RAS pointer to restore
- rec_ras_cnt  in  $clog2(RAS_DEPTH)+1  RAS occupancy to restore

Behaviour:
- Reset: all PHT counters = 2**(CTR_W-1)-1 (weakly not-taken); history = 0; RAS ptr = 0, cnt = 0; all outputs 0.
- Index: MODE 0 uses lk_pc[2 +: IDX_W]. MODE 1 uses lk_pc[2 +: IDX_W] XOR zero-extended history. Updates compute the index the same way from upd_pc/upd_hist.
- Lookup latency is 1 cycle. Counter, history snapshot and RAS snapshot are registered at lk_valid; pred_* and ckpt_* are valid the following cycle while pred_valid = 1.
- pred_taken = MSB of the indexed counter, and only when lk_is_br.
- Speculative history: on lk_valid && lk_is_br, history <= {history[HIST_W-2:0], predicted bit} at the clock edge. HIST_W = 0 means no history.
- PHT update is a single-cycle read-modify-write on upd_valid: increment on taken, decrement on not-taken, saturating at all-ones and zero.
- Update and lookup to the same index in the same cycle: the lookup returns the pre-update value (read-before-write).
- RAS push: ptr <= ptr+1 (mod RAS_DEPTH); entry[ptr+1] <= lk_pc+4; cnt saturates at RAS_DEPTH. When full, the oldest entry is overwritten silently.
- RAS pop: ras_target = entry[ptr]; ras_valid = (cnt != 0); ptr <= ptr-1 and cnt <= cnt-1 only if cnt != 0. Pop on empty leaves state unchanged.
- Push and pop in the same lookup (co-routine): entry[ptr] is overwritten with lk_pc+4; ptr and cnt are unchanged; ras_target is the old entry[ptr].
- Recovery: rec_valid has priority over any same-cycle speculative history or RAS change. history <= rec_hist, ptr <= rec_ras_ptr, cnt <= rec_ras_cnt. RAS entry contents are not restored. A lookup in the same cycle is dropped: pred_valid = 0 next cycle.
- upd_valid is independent of rec_valid; both may be asserted in the same cycle.
- rst mid-operation discards any in-flight prediction; pred_valid = 0 the next cycle.

Decomposition:
- Shared package (rv32i_types): opcode constants and a bp_ckpt_t struct {hist, ras_ptr, ras_cnt} sized from package-level BP_HIST_W and BP_RAS_DEPTH constants.
- One sub-module: ras_circ (parametrised circular stack with push, pop, push+pop, and restore).
- The PHT stays inline as a flop array.

Test Plan:
- Reset, then lookup lk_pc=0x1eceb000 with lk_is_br=1 -> next cycle pred_valid=1, pred_taken=0, ckpt_hist=0, ckpt_ras_cnt=0.
- MODE=0: three upd_valid taken on pc 0x1eceb010 -> counter reaches 3, lookup predicts taken. Fourth update (taken) keeps the counter at 3. Four not-taken updates -> 0, no underflow.
- RAS_DEPTH=4: push 5 times from pcs 0x100,0x200,0x300,0x400,0x500 -> pops return 0x504,0x404,0x304,0x204 with ras_valid=1. The fifth pop gives ras_valid=0 and cnt stays 0.
- Push+pop together at pc 0x600 with cnt=2 -> ras_target = old top, new top = 0x604, cnt remains 2.
- MODE=1, HIST_W=6: two predicted-taken branches -> history 6'b000011. rec_valid with rec_hist=6'b000001, rec_ras_ptr=1, rec_ras_cnt=1, asserted together with a lookup -> history = 000001 and pred_valid=0 next cycle.
- upd_valid and lk_valid on the same index in the same cycle -> the prediction reflects the old counter; a lookup one cycle later reflects the new value.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: opcode constants and branch-predictor checkpoint payload.
package rv32i_types;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int unsigned BP_HIST_W     = 6;
  localparam int unsigned BP_RAS_DEPTH  = 4;
  localparam int unsigned BP_RAS_PTR_W  = $clog2(BP_RAS_DEPTH);

  // State captured at lookup time and handed back on a mispredict.
  typedef struct packed {
    logic [BP_HIST_W-1:0]  hist;
    logic [BP_RAS_PTR_W-1:0] ras_ptr;
    logic [BP_RAS_PTR_W:0]   ras_cnt;
  } bp_ckpt_t;

  // True for any control-transfer opcode the fetch stage must predict.
  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/ras_circ.sv
// Circular return-address stack; overflow silently overwrites the oldest entry.
module ras_circ #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [31:0]                push_data,
  input  logic                       restore,
  input  logic [$clog2(DEPTH)-1:0]   restore_ptr,
  input  logic [$clog2(DEPTH):0]     restore_cnt,
  output logic [$clog2(DEPTH)-1:0]   ptr,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic [31:0]                top_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0] ent [DEPTH];

  // Pointer and occupancy; restore beats any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (restore) begin
      ptr <= restore_ptr;
      cnt <= restore_cnt;
    end else if (push && !pop) begin
      ptr <= ptr + PW'(1);
      if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
    end else if (pop && !push && (cnt != '0)) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end

  // Entry storage; push+pop replaces the top in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ent[i] <= '0;
    end else if (!restore) begin
      if (push && pop)  ent[ptr] <= push_data;
      else if (push)    ent[ptr + PW'(1)] <= push_data;
    end
  end

  assign top_c = ent[ptr];

endmodule

// File: rtl/bp_gshare_ras.sv
// Fetch-stage direction predictor (bimodal/gshare PHT) with speculative history and RAS.
module bp_gshare_ras
  import rv32i_types::*;
#(
  parameter int unsigned IDX_W     = 9,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned HIST_W    = BP_HIST_W,
  parameter int unsigned MODE      = 1,
  parameter int unsigned RAS_DEPTH = BP_RAS_DEPTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    lk_valid,
  input  logic [31:0]                             lk_pc,
  input  logic                                    lk_is_br,
  input  logic                                    lk_push,
  input  logic                                    lk_pop,
  output logic                                    pred_valid,
  output logic                                    pred_taken,
  output logic                                    ras_valid,
  output logic [31:0]                             ras_target,
  output logic [((HIST_W > 0) ? HIST_W : 1)-1:0]  ckpt_hist,
  output logic [$clog2(RAS_DEPTH)-1:0]            ckpt_ras_ptr,
  output logic [$clog2(RAS_DEPTH):0]              ckpt_ras_cnt,
  input  logic                                    upd_valid,
  input  logic [31:0]                             upd_pc,
  input  logic [((HIST_W > 0) ? HIST_W : 1)-1:0]  upd_hist,
  input  logic                                    upd_taken,
  input  logic                                    rec_valid,
  input  logic [((HIST_W > 0) ? HIST_W : 1)-1:0]  rec_hist,
  input  logic [$clog2(RAS_DEPTH)-1:0]            rec_ras_ptr,
  input  logic [$clog2(RAS_DEPTH):0]              rec_ras_cnt
);

  localparam int unsigned HW      = (HIST_W > 0) ? HIST_W : 1;
  localparam int unsigned PW      = $clog2(RAS_DEPTH);
  localparam int unsigned N_ENT   = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [CTR_W-1:0] pht [N_ENT];
  logic [HW-1:0]    hist;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [CTR_W-1:0] lk_ctr;
  logic [CTR_W-1:0] upd_ctr;
  logic [CTR_W-1:0] upd_ctr_nxt;
  logic             lk_dir;
  logic             lk_go;
  logic [PW-1:0]    ras_ptr;
  logic [PW:0]      ras_cnt;
  logic [31:0]      ras_top_c;
  logic             unused_bits;

  assign unused_bits = ^{upd_pc[31:IDX_W+2], upd_pc[1:0], upd_hist};

  // Lookup and update indices; history folds in only for gshare.
  always_comb begin
    lk_idx  = lk_pc[2 +: IDX_W];
    upd_idx = upd_pc[2 +: IDX_W];
    if ((MODE != 0) && (HIST_W != 0)) begin
      lk_idx  = lk_idx ^ IDX_W'(hist);
      upd_idx = upd_idx ^ IDX_W'(upd_hist);
    end
  end

  // Counter read for lookup and saturating next value for update.
  always_comb begin
    lk_ctr      = pht[lk_idx];
    lk_dir      = lk_ctr[CTR_W-1];
    upd_ctr     = pht[upd_idx];
    upd_ctr_nxt = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_nxt = upd_ctr + CTR_W'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr_nxt = upd_ctr - CTR_W'(1);
    end
  end

  // PHT storage; lookup sees the pre-update value because it reads the flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_ENT); i++) pht[i] <= CTR_INIT;
    end else if (upd_valid) begin
      pht[upd_idx] <= upd_ctr_nxt;
    end
  end

  // Speculative global history; recovery wins over a same-cycle shift.
  always_ff @(posedge clk) begin
    if (rst || (HIST_W == 0)) begin
      hist <= '0;
    end else if (rec_valid) begin
      hist <= rec_hist;
    end else if (lk_valid && lk_is_br) begin
      hist <= HW'({hist, lk_dir});
    end
  end

  assign lk_go = lk_valid && !rec_valid;

  ras_circ #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push        (lk_go && lk_push),
    .pop         (lk_go && lk_pop),
    .push_data   (lk_pc + 32'd4),
    .restore     (rec_valid),
    .restore_ptr (rec_ras_ptr),
    .restore_cnt (rec_ras_cnt),
    .ptr         (ras_ptr),
    .cnt         (ras_cnt),
    .top_c       (ras_top_c)
  );

  // Registered prediction and checkpoint, one cycle after an accepted lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      ras_valid    <= 1'b0;
      ras_target   <= '0;
      ckpt_hist    <= '0;
      ckpt_ras_ptr <= '0;
      ckpt_ras_cnt <= '0;
    end else begin
      pred_valid <= lk_go;
      if (lk_go) begin
        pred_taken   <= lk_is_br && lk_dir;
        ras_valid    <= lk_pop && (ras_cnt != '0);
        ras_target   <= ras_top_c;
        ckpt_hist    <= hist;
        ckpt_ras_ptr <= ras_ptr;
        ckpt_ras_cnt <= ras_cnt;
      end
    end
  end

endmodule
